// File: rtl/mix_engine.sv
// Four-voice drum mixer: per-voice gain/mute, sum, 16-bit PCM, FWFT output FIFO.
// Optional MIX_SATURATE_EN selects saturation; otherwise out-of-range samples wrap.
module mix_engine #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic [7:0]  audio0,
    input  logic [7:0]  audio1,
    input  logic [7:0]  audio2,
    input  logic [7:0]  audio3,
    input  logic [15:0] gain,
    input  logic [3:0]  mute,
    input  logic        out_ready,
    input  logic        clear_flags,
    output logic        mix_valid,
    output logic [31:0] mix_down,
    output logic        clip,
    output logic        overrun
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [2:0]        vld_q;
    logic [3:0][7:0]   aud_q;
    logic [15:0]       gain_q;
    logic [3:0]        mute_q;
    logic signed [8:0]  s_d [4];
    logic signed [13:0] p_d [4];
    logic signed [13:0] p_q [4];
    logic signed [15:0] sum_d, sum_q;
    logic signed [20:0] wide;
    logic               ovf;
    logic [15:0]        sample16;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clip_q, clip_d, ovr_q, ovr_d;
    logic          push, pop, full, push_ok;

    always_ff @(posedge clk) begin
        if (!reset) vld_q <= '0;
        else        vld_q <= {vld_q[1:0], sample_tick};
    end

    // Stage 0 only loads on a tick so later input changes never reach queued samples.
    always_ff @(posedge clk) begin
        if (sample_tick) begin
            aud_q  <= {audio3, audio2, audio1, audio0};
            gain_q <= gain;
            mute_q <= mute;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s_d[k] = $signed({1'b0, aud_q[k]} - 9'd128);
            p_d[k] = mute_q[k] ? 14'sd0
                   : 14'(s_d[k] * $signed({1'b0, gain_q[4*k +: 4]}));
        end
        sum_d = 16'(p_q[0]) + 16'(p_q[1]) + 16'(p_q[2]) + 16'(p_q[3]);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) p_q[k] <= p_d[k];
        sum_q <= sum_d;
    end

    always_comb begin
        wide = {sum_q, 5'b0};
        ovf  = (wide[20:15] != {6{wide[15]}});
`ifdef MIX_SATURATE_EN
        sample16 = ovf ? (wide[20] ? 16'h8000 : 16'h7FFF) : wide[15:0];
`else
        sample16 = wide[15:0];
`endif
    end

    assign mix_valid = (cnt_q != '0);
    assign mix_down  = mix_valid ? mem_q[rd_q] : 32'h0;
    assign clip      = clip_q;
    assign overrun   = ovr_q;

    always_comb begin
        push    = vld_q[2];
        pop     = mix_valid & out_ready;
        full    = (cnt_q == CW'(FIFO_DEPTH));
        push_ok = push & (~full | pop);
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // A new event wins over a simultaneous clear.
        clip_d = (clip_q & ~clear_flags) | (push & ovf);
        ovr_d  = (ovr_q & ~clear_flags) | (push & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            clip_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            clip_q <= clip_d;
            ovr_q  <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= {sample16, sample16};
    end
endmodule

// File: doc/mix_engine.md
# mix_engine

Pipelined four-voice drum mixer sitting between the four sample players and the audio codec interface. On each sample-rate tick it snapshots the four unsigned 8-bit voice outputs, applies per-voice gain and mute, sums, saturates to 16-bit signed PCM and queues the result in a small output FIFO. The audio codec interface drains the FIFO through a valid/ready handshake as a 32-bit left/right word.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-low reset
- sample_tick  in  1  one-cycle pulse per audio sample period
- audio0..audio3  in  8 each  voice samples, offset binary (128 = silence)
- gain  in  16  per-voice gain, voice k in gain[4k+3:4k], unsigned 0..15, unity = 8
- mute  in  4  mute[k]=1 forces voice k contribution to 0
- out_ready  in  1  codec interface accepts mix_down this cycle
- clear_flags  in  1  clears clip and overrun
- mix_valid  out  1  FIFO head valid
- mix_down  out  32  {sample16, sample16}; 0 when mix_valid=0
- clip  out  1  sticky: a sample exceeded 16-bit signed range
- overrun  out  1  sticky: a sample was dropped because FIFO was full

## Operation
- Stage 0 (edge N, sample_tick high in preceding cycle): register audio0..3, gain, mute; set v0.
- Stage 1 (edge N+1): s_k = audio_k − 128 (9-bit signed); p_k = mute[k] ? 0 : s_k × gain_k (14-bit signed); set v1.
- Stage 2 (edge N+2): sum = Σp_k (16-bit signed, range −7680..+7620); set v2.
- Stage 3 (edge N+3): wide = sum << 5 (21-bit signed); sample16 = saturate to [−32768, 32767]; if wide out of range set clip; push {sample16, sample16} into FIFO; set overrun instead if FIFO full and no pop this edge.
- Fully pipelined: back-to-back ticks each produce one sample, in order.
- FIFO is first-word-fall-through: mix_valid = (count≠0), mix_down = head entry.
- Pop on any edge with mix_valid & out_ready.
- Full with simultaneous push and pop: both happen, count unchanged, no overrun.
- Empty with simultaneous push and pop: pop ignored (mix_valid was 0); push accepted.
- clear_flags and a new clip/overrun event on the same edge: flag ends set.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (reset=0 at an edge): v0..v2, FIFO pointers/count, clip, overrun cleared; mix_valid=0, mix_down=0, clip=0, overrun=0 after that edge. In-flight samples discarded.
- Latency: tick sampled at edge N → mix_valid=1 after edge N+3 when FIFO was empty.
- Throughput: one sample per cycle in, one per cycle out.
- Inputs other than sample_tick are only sampled at stage 0; changes between ticks have no effect on queued samples.
- out_ready has no combinational path to mix_valid or mix_down.

## Configuration
- MIX_SATURATE_EN defined: stage 3 saturates as above.
- MIX_SATURATE_EN undefined: sample16 = wide[15:0] (two's-complement wrap); clip still set on out-of-range, detection logic unchanged.

## Test plan
- Reset: hold reset=0 3 cycles with ticks active → mix_valid=0, mix_down=0, clip=0, overrun=0 throughout and 4 cycles after release with no tick.
- Single voice: audio0=255, others 128, gain=16'h8888, mute=0, out_ready=1, one tick → mix_valid=1 exactly 3 edges later, mix_down=32'h7F007F00, clip=0.
- Saturation: audio0=audio1=255, others 128, gain=16'hFFFF, tick → mix_down=32'h7FFF7FFF, clip=1; all voices 0 → 32'h80008000. Without MIX_SATURATE_EN first case → 32'hDC40DC40, clip=1.
- Mute: single-voice setup with mute=4'b0001 → mix_down=32'h00000000, mix_valid=1.
- Backpressure: out_ready=0, 5 ticks with audio0 = 129,130,131,132,133 (gain 8) → FIFO holds 4, overrun=1; out_ready=1 → 4 consecutive pops 32'h01000100, 0200…, 0300…, 0400…, then mix_valid=0; clear_flags → overrun=0.
- Reset mid-operation: tick, then reset=0 at edge N+1 for one cycle → no mix_valid ever asserted for that tick.
